// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter.
// Grants one of N requesters at a time. A grant is held until the owner
// signals done, drops its request, or the hold limit runs out. Every
// release advances the rotation pointer past the owner, and an idle
// bubble cycle always separates consecutive grants.
`timescale 1ns/1ps

module rr_grant_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             timeout_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Last hold count value before the grant is forced off.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);

  state_t            state_q;
  logic [N-1:0]      gnt_q;
  logic [IDX_W-1:0]  gnt_idx_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              timeout_q;

  logic [N-1:0]      req_hi_d;     // requests at or above the pointer
  logic [IDX_W-1:0]  hi_idx_d;
  logic              hi_found_d;
  logic [IDX_W-1:0]  lo_idx_d;
  logic [IDX_W-1:0]  win_idx_d;
  logic [N-1:0]      win_onehot_d;
  logic              owner_req_d;
  logic [IDX_W-1:0]  ptr_adv_d;

  // Mask off requesters below the rotation pointer.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req_mask
      assign req_hi_d[gi] = req_i[gi] && (IDX_W'(gi) >= ptr_q);
    end
  endgenerate

  // Lowest masked requester wins; fall back to the lowest requester overall.
  always_comb begin
    hi_idx_d   = '0;
    hi_found_d = 1'b0;
    lo_idx_d   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx_d = IDX_W'(i);
      end
      if (req_hi_d[i]) begin
        hi_idx_d   = IDX_W'(i);
        hi_found_d = 1'b1;
      end
    end
    win_idx_d    = hi_found_d ? hi_idx_d : lo_idx_d;
    win_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx_d;
  end

  // Owner's request level and the pointer value used on release.
  assign owner_req_d = req_i[gnt_idx_q];
  assign ptr_adv_d   = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + 1'b1;

  // Arbitration FSM with registered grant, index and timeout outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (|req_i) begin
            state_q    <= GRANT;
            gnt_q      <= win_onehot_d;
            gnt_idx_q  <= win_idx_d;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (done_i || !owner_req_d) begin
            // Normal release wins over the hold limit in the same cycle.
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= ptr_adv_d;
            timeout_q <= 1'b0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= ptr_adv_d;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
            timeout_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          gnt_q     <= '0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = |gnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: a session-level model predicts the
// outputs after each clock edge, a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_rr_grant_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_grant_arbiter #(.N(N), .IDX_W(3), .MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .done_i     (done),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic       valid;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model: grant session state.
  int m_owner;   // -1 when nobody holds the resource
  int m_held;    // cycles the current grant has been visible
  int m_ptr;
  int m_last;
  bit m_to;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_to = 1'b0;
  endtask

  task automatic model_update(input logic [7:0] r, input logic d);
    if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (r[c] && m_owner < 0) begin
          m_owner = c; m_held = 1; m_last = c;
        end
      end
    end else if (d || !r[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_to = 1'b0;
    end else if (m_held == MAX_HOLD) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_to = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.gnt   = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    e.valid = (m_owner >= 0);
    e.idx   = 3'(m_last);
    e.to    = m_to;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, want);
    end
  endtask

  // Monitor: one compare set per cycle against the oldest prediction.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty cycle=%0d got=none exp=entry", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("gnt_valid", gnt_valid, e.valid);
        chk("gnt_idx", gnt_idx, e.idx);
        chk("timeout", timeout, e.to);
        $display("cycle=%0d req=%h done=%0d gnt=%h idx=%0d valid=%0d timeout=%0d",
                 cyc, req, done, gnt, gnt_idx, gnt_valid, timeout);
      end
    end
  end

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    model_update(r, d);
    push_exp();
    @(posedge clk);
    #1;
  endtask

  // Release reset (called just after an edge) and restart the scoreboard.
  task automatic restart(input logic [7:0] r);
    req   = r;
    done  = 1'b0;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    push_exp();
    mon_en = 1'b1;
  endtask

  logic [7:0] rr;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", gnt, 0);
    chk("reset_valid", gnt_valid, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_idx", gnt_idx, 0);
    restart(8'h00);

    // Reset mid-grant drops the grant asynchronously.
    step(8'h04, 1'b0);
    step(8'h04, 1'b0);
    chk("pre_reset_gnt", gnt, 8'h04);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_gnt", gnt, 0);
    chk("async_reset_valid", gnt_valid, 0);
    chk("async_reset_timeout", timeout, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    restart(8'h04);
    step(8'h04, 1'b0);  // first grant again to index 2

    // Park the pointer at 0, then rotate through all requesters.
    step(8'h00, 1'b0);
    step(8'h80, 1'b0);
    step(8'h80, 1'b1);
    repeat (18) step(8'hFF, m_owner >= 0);

    // Wrap-around: serve 5 (ptr=6), then 0x09 -> 0, then 3.
    step(8'h20, 1'b0);
    step(8'h20, 1'b1);
    step(8'h09, 1'b0);
    step(8'h09, 1'b1);
    step(8'h09, 1'b0);
    step(8'h09, 1'b1);

    // Hold limit: forced release, timeout pulse, re-grant.
    repeat (40) step(8'h20, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // done together with the hold limit is a normal release.
    repeat (20) step(8'h20, (m_owner >= 0) && (m_held == MAX_HOLD));
    step(8'h00, 1'b0);

    // Owner drop while another requester waits.
    step(8'h08, 1'b0);
    step(8'h18, 1'b0);
    step(8'h18, 1'b0);
    step(8'h10, 1'b0);
    step(8'h10, 1'b0);
    step(8'h10, 1'b1);

    // Randomized traffic with sticky requests.
    rr = 8'hFF;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0) rr = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rr = 8'h00;
      step(rr, $urandom_range(0, 9) == 0);
    end
    step(8'h00, 1'b1);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
